// File: rtl/isp_gamma_pwl_if.sv
`default_nettype none
// ============================================================================
//  Module      : isp_gamma_pwl_if
//  Description : Pixel stream and knot-table configuration bus for the
//                piecewise-linear gamma block. The master side drives the
//                pixels and configuration; the slave side is the gamma core.
//  Revision    : 1.0  initial release
// ============================================================================
interface isp_gamma_pwl_if #(
    parameter int IN_BITS  = 12,
    parameter int OUT_BITS = 8,
    parameter int SEG_BITS = 6
);
    // Pixel input stream
    logic                in_href;
    logic                in_vsync;
    logic [IN_BITS-1:0]  in_data_r;
    logic [IN_BITS-1:0]  in_data_g;
    logic [IN_BITS-1:0]  in_data_b;

    // Pixel output stream
    logic                out_href;
    logic                out_vsync;
    logic [OUT_BITS-1:0] out_data_r;
    logic [OUT_BITS-1:0] out_data_g;
    logic [OUT_BITS-1:0] out_data_b;

    // Knot-table configuration
    logic                cfg_wen;
    logic                cfg_ren;
    logic [1:0]          cfg_chan;
    logic [SEG_BITS:0]   cfg_addr;
    logic [OUT_BITS-1:0] cfg_wdata;
    logic [OUT_BITS-1:0] cfg_rdata;
    logic                cfg_bypass;
    logic                cfg_commit;
    logic                cfg_pending;

    modport master (
        output in_href, in_vsync, in_data_r, in_data_g, in_data_b,
        output cfg_wen, cfg_ren, cfg_chan, cfg_addr, cfg_wdata,
        output cfg_bypass, cfg_commit,
        input  out_href, out_vsync, out_data_r, out_data_g, out_data_b,
        input  cfg_rdata, cfg_pending
    );

    modport slave (
        input  in_href, in_vsync, in_data_r, in_data_g, in_data_b,
        input  cfg_wen, cfg_ren, cfg_chan, cfg_addr, cfg_wdata,
        input  cfg_bypass, cfg_commit,
        output out_href, out_vsync, out_data_r, out_data_g, out_data_b,
        output cfg_rdata, cfg_pending
    );
endinterface
`default_nettype wire

// File: rtl/isp_gamma_pwl.sv
`default_nettype none
// ============================================================================
//  Module      : isp_gamma_pwl
//  Description : Per-channel piecewise-linear gamma curve. Each channel owns
//                two knot banks (active for pixels, shadow for the config
//                port); a committed bank swap is taken on the next rising
//                edge of vsync. Three-stage pipeline: knot lookup,
//                interpolation, output gating.
//                Legal parameters: OUT_BITS <= IN_BITS, 1 <= SEG_BITS <= IN_BITS.
//  Revision    : 1.0  initial release
// ============================================================================
module isp_gamma_pwl #(
    parameter int IN_BITS  = 12,
    parameter int OUT_BITS = 8,
    parameter int SEG_BITS = 6
) (
    input  logic            pclk,
    input  logic            rst,
    isp_gamma_pwl_if.slave  bus
);
    localparam int FRAC  = IN_BITS - SEG_BITS;
    localparam int NSEG  = 1 << SEG_BITS;
    localparam int NKNOT = NSEG + 1;
    localparam int AW    = SEG_BITS + 1;

    // knots[channel][bank][index]; contents survive reset on purpose
    logic [OUT_BITS-1:0] knots [0:2][0:1][0:NKNOT-1];

    logic                active_bank;
    logic                bypass_active;
    logic                pending;
    logic                vsync_prev;
    logic                vsync_edge;
    logic                swap;
    logic                cfg_in_range;
    logic [OUT_BITS-1:0] rdata_q;

    logic                s1_href;
    logic                s1_vsync;
    logic                s1_bypass;
    logic                s2_href;
    logic                s2_vsync;
    logic                out_href_q;
    logic                out_vsync_q;

    assign vsync_edge   = bus.in_vsync & ~vsync_prev;
    // A commit arriving on the edge cycle itself is honoured immediately
    assign swap         = vsync_edge & (pending | bus.cfg_commit);
    assign cfg_in_range = (bus.cfg_chan != 2'd3) && (bus.cfg_addr <= AW'(NSEG));

    assign bus.cfg_pending = pending;
    assign bus.cfg_rdata   = rdata_q;
    assign bus.out_href    = out_href_q;
    assign bus.out_vsync   = out_vsync_q;

    // Shadow-bank knot writes; blocked while a swap is armed so the bank
    // being handed to the pixel path cannot change under it
    always_ff @(posedge pclk) begin
        if (bus.cfg_wen && !pending && cfg_in_range) begin
            knots[bus.cfg_chan][~active_bank][bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // Bank selection, bypass mode and commit/swap bookkeeping.
    // The edge register samples vsync during reset so that a vsync already
    // high when reset is released is not mistaken for a rising edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            active_bank   <= 1'b0;
            bypass_active <= 1'b1;
            pending       <= 1'b0;
            vsync_prev    <= bus.in_vsync;
        end else begin
            vsync_prev <= bus.in_vsync;
            if (swap) begin
                active_bank   <= ~active_bank;
                bypass_active <= bus.cfg_bypass;
                pending       <= 1'b0;
            end else if (bus.cfg_commit) begin
                pending <= 1'b1;
            end
        end
    end

    // Shadow-bank readback; holds its value between read strobes
    always_ff @(posedge pclk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (bus.cfg_ren) begin
            rdata_q <= cfg_in_range ? knots[bus.cfg_chan][~active_bank][bus.cfg_addr] : '0;
        end
    end

    // Sync/qualifier pipeline shared by the three channels
    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_href     <= 1'b0;
            s1_vsync    <= 1'b0;
            s1_bypass   <= 1'b1;
            s2_href     <= 1'b0;
            s2_vsync    <= 1'b0;
            out_href_q  <= 1'b0;
            out_vsync_q <= 1'b0;
        end else begin
            s1_href     <= bus.in_href;
            s1_vsync    <= bus.in_vsync;
            s1_bypass   <= bypass_active;
            s2_href     <= s1_href;
            s2_vsync    <= s1_vsync;
            out_href_q  <= s2_href;
            out_vsync_q <= s2_vsync;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        logic [IN_BITS-1:0]  pix;
        logic [AW-1:0]       idx;
        logic [OUT_BITS-1:0] s1_k0;
        logic [OUT_BITS-1:0] s1_trunc;
        logic [OUT_BITS-1:0] interp;
        logic [OUT_BITS-1:0] s2_data;
        logic [OUT_BITS-1:0] out_q;

        assign pix = (c == 0) ? bus.in_data_r :
                     (c == 1) ? bus.in_data_g : bus.in_data_b;

        if (FRAC == 0) begin : g_nofrac
            // Every input code is a knot: no interpolation
            assign idx    = {1'b0, pix};
            assign interp = s1_k0;
        end else begin : g_frac
            localparam int PW   = OUT_BITS + FRAC + 2;
            localparam int HALF = 1 << (FRAC - 1);

            logic [OUT_BITS-1:0] s1_k1;
            logic [FRAC-1:0]     s1_f;
            logic signed [OUT_BITS:0] diff;
            logic signed [PW-1:0]     prod;

            assign idx = {1'b0, pix[IN_BITS-1:FRAC]};

            // Upper knot and fraction captured alongside the lower knot
            always_ff @(posedge pclk) begin
                if (rst) begin
                    s1_k1 <= '0;
                    s1_f  <= '0;
                end else begin
                    s1_k1 <= knots[c][active_bank][idx + AW'(1)];
                    s1_f  <= pix[FRAC-1:0];
                end
            end

            // Signed slope times fraction, round-half-up then arithmetic
            // shift, which floors negative results on descending segments
            always_comb begin
                diff   = $signed({1'b0, s1_k1}) - $signed({1'b0, s1_k0});
                prod   = PW'(diff) * PW'($signed({1'b0, s1_f})) + PW'(HALF);
                interp = OUT_BITS'(PW'($signed({1'b0, s1_k0})) + (prod >>> FRAC));
            end
        end

        // Stage 1: lower-knot lookup on the bank active at this edge
        always_ff @(posedge pclk) begin
            if (rst) begin
                s1_k0    <= '0;
                s1_trunc <= '0;
            end else begin
                s1_k0    <= knots[c][active_bank][idx];
                s1_trunc <= pix[IN_BITS-1 -: OUT_BITS];
            end
        end

        // Stage 2: choose truncated bypass value or interpolated curve
        always_ff @(posedge pclk) begin
            if (rst) begin
                s2_data <= '0;
            end else begin
                s2_data <= s1_bypass ? s1_trunc : interp;
            end
        end

        // Stage 3: blank data outside the active line
        always_ff @(posedge pclk) begin
            if (rst) begin
                out_q <= '0;
            end else begin
                out_q <= s2_href ? s2_data : '0;
            end
        end
    end

    assign bus.out_data_r = g_chan[0].out_q;
    assign bus.out_data_g = g_chan[1].out_q;
    assign bus.out_data_b = g_chan[2].out_q;

endmodule
`default_nettype wire

// File: tb/tb_isp_gamma_pwl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isp_gamma_pwl
//  Description : Directed self-checking bench for isp_gamma_pwl
//  Revision    : 1.0  initial release
// ============================================================================
module tb_isp_gamma_pwl;
    localparam int IN_BITS  = 12;
    localparam int OUT_BITS = 8;
    localparam int SEG_BITS = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    isp_gamma_pwl_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .SEG_BITS(SEG_BITS)) bus ();

    isp_gamma_pwl #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .SEG_BITS(SEG_BITS)) dut (
        .pclk (clk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [11:0] r;
        logic [11:0] g;
        logic [11:0] b;
        logic [7:0]  er;
        logic [7:0]  eg;
        logic [7:0]  eb;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] chan, input logic [6:0] addr, input logic [7:0] data);
        bus.cfg_chan  = chan;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        bus.cfg_wen   = 1'b1;
        tick();
        bus.cfg_wen   = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] chan, input logic [6:0] addr,
                            input logic [7:0] exp, input string name);
        bus.cfg_chan = chan;
        bus.cfg_addr = addr;
        bus.cfg_ren  = 1'b1;
        tick();
        bus.cfg_ren  = 1'b0;
        bus.cfg_addr = addr ^ 7'd1;
        check(name, 32'(bus.cfg_rdata), 32'(exp));
        tick();
        check({name, "_hold"}, 32'(bus.cfg_rdata), 32'(exp));
    endtask

    task automatic commit_pulse;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
    endtask

    task automatic pixel_check(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                               input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                               input string name);
        bus.in_href   = 1'b1;
        bus.in_data_r = r;
        bus.in_data_g = g;
        bus.in_data_b = b;
        tick();
        bus.in_href   = 1'b0;
        bus.in_data_r = '0;
        bus.in_data_g = '0;
        bus.in_data_b = '0;
        tick();
        tick();
        check({name, "_href"}, 32'(bus.out_href), 32'd1);
        check({name, "_r"}, 32'(bus.out_data_r), 32'(er));
        check({name, "_g"}, 32'(bus.out_data_g), 32'(eg));
        check({name, "_b"}, 32'(bus.out_data_b), 32'(eb));
    endtask

    initial begin
        // Ch0: plain 4i curve; ch1: descending segment 5->6; ch2: top segment 250->255
        vecs[0] = '{12'h060, 12'h060, 12'h060, 8'd6,   8'd6,   8'd6};
        vecs[1] = '{12'h000, 12'h170, 12'hFFF, 8'd0,   8'd55,  8'd255};
        vecs[2] = '{12'hFFF, 12'h140, 12'hFC0, 8'd255, 8'd100, 8'd250};
        vecs[3] = '{12'h7E0, 12'h180, 12'hFE0, 8'd126, 8'd40,  8'd253};
        vecs[4] = '{12'h01F, 12'h13F, 12'hFBF, 8'd2,   8'd99,  8'd250};
        vecs[5] = '{12'h010, 12'h1BF, 12'h060, 8'd1,   8'd28,  8'd6};
        vecs[6] = '{12'h008, 12'h160, 12'h000, 8'd1,   8'd70,  8'd0};
        vecs[7] = '{12'h007, 12'h000, 12'hFFF, 8'd0,   8'd0,   8'd255};

        rst            = 1'b1;
        bus.in_href    = 1'b0;
        bus.in_vsync   = 1'b0;
        bus.in_data_r  = '0;
        bus.in_data_g  = '0;
        bus.in_data_b  = '0;
        bus.cfg_wen    = 1'b0;
        bus.cfg_ren    = 1'b0;
        bus.cfg_chan   = '0;
        bus.cfg_addr   = '0;
        bus.cfg_wdata  = '0;
        bus.cfg_bypass = 1'b1;
        bus.cfg_commit = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_href",  32'(bus.out_href), 32'd0);
        check("rst_out_vsync", 32'(bus.out_vsync), 32'd0);
        check("rst_out_r",     32'(bus.out_data_r), 32'd0);
        check("rst_pending",   32'(bus.cfg_pending), 32'd0);
        check("rst_rdata",     32'(bus.cfg_rdata), 32'd0);

        // Bypass after reset: truncation with a 3-cycle latency, zero outside href
        bus.in_href   = 1'b1;
        bus.in_data_r = 12'hABC;
        bus.in_data_g = 12'h123;
        bus.in_data_b = 12'hFFF;
        tick();
        bus.in_href   = 1'b0;
        bus.in_data_r = 12'h555;
        bus.in_data_g = 12'h555;
        bus.in_data_b = 12'h555;
        check("byp_lat1_href", 32'(bus.out_href), 32'd0);
        tick();
        check("byp_lat2_href", 32'(bus.out_href), 32'd0);
        tick();
        check("byp_href", 32'(bus.out_href), 32'd1);
        check("byp_r", 32'(bus.out_data_r), 32'h0AB);
        check("byp_g", 32'(bus.out_data_g), 32'h012);
        check("byp_b", 32'(bus.out_data_b), 32'h0FF);
        tick();
        check("blank_href", 32'(bus.out_href), 32'd0);
        check("blank_r", 32'(bus.out_data_r), 32'd0);
        check("blank_b", 32'(bus.out_data_b), 32'd0);
        bus.in_data_r = '0;
        bus.in_data_g = '0;
        bus.in_data_b = '0;

        // Load k[i] = min(4i,255) into the shadow bank of every channel
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i <= 64; i++) begin
                cfg_write(2'(c), 7'(i), (4 * i > 255) ? 8'd255 : 8'(4 * i));
            end
        end
        cfg_write(2'd1, 7'd5, 8'd100);
        cfg_write(2'd1, 7'd6, 8'd40);
        cfg_write(2'd2, 7'd63, 8'd250);
        cfg_write(2'd2, 7'd64, 8'd255);

        cfg_read(2'd1, 7'd5,  8'd100, "rd_g5");
        cfg_read(2'd0, 7'd10, 8'd40,  "rd_r10");
        cfg_read(2'd0, 7'd65, 8'd0,   "rd_addr65");
        cfg_read(2'd3, 7'd5,  8'd0,   "rd_chan3");

        // Commit; swap waits for the vsync rise
        bus.cfg_bypass = 1'b0;
        commit_pulse();
        check("commit_pending", 32'(bus.cfg_pending), 32'd1);
        tick();
        check("commit_pending_hold", 32'(bus.cfg_pending), 32'd1);
        pixel_check(12'hABC, 12'h170, 12'h060, 8'hAB, 8'h17, 8'h06, "pre_swap_byp");

        bus.in_vsync = 1'b1;
        tick();
        check("swap_pending_clr", 32'(bus.cfg_pending), 32'd0);
        check("vs_lat1", 32'(bus.out_vsync), 32'd0);
        tick();
        check("vs_lat2", 32'(bus.out_vsync), 32'd0);
        tick();
        check("vs_lat3", 32'(bus.out_vsync), 32'd1);
        bus.in_vsync = 1'b0;
        repeat (3) tick();

        // Streamed table vectors: one pixel per cycle, result three cycles later
        for (int j = 0; j < NVEC + 2; j++) begin
            if (j < NVEC) begin
                bus.in_href   = 1'b1;
                bus.in_data_r = vecs[j].r;
                bus.in_data_g = vecs[j].g;
                bus.in_data_b = vecs[j].b;
            end else begin
                bus.in_href   = 1'b0;
                bus.in_data_r = '0;
                bus.in_data_g = '0;
                bus.in_data_b = '0;
            end
            tick();
            if (j >= 2) begin
                check($sformatf("vec%0d_href", j - 2), 32'(bus.out_href), 32'd1);
                check($sformatf("vec%0d_r", j - 2), 32'(bus.out_data_r), 32'(vecs[j-2].er));
                check($sformatf("vec%0d_g", j - 2), 32'(bus.out_data_g), 32'(vecs[j-2].eg));
                check($sformatf("vec%0d_b", j - 2), 32'(bus.out_data_b), 32'(vecs[j-2].eb));
            end
        end
        tick();
        check("vec_drain_href", 32'(bus.out_href), 32'd0);

        // Writes are dropped while a swap is pending
        cfg_write(2'd0, 7'd3, 8'h11);
        cfg_read(2'd0, 7'd3, 8'h11, "rd_shadow0_a3");
        bus.cfg_bypass = 1'b1;
        commit_pulse();
        check("commit2_pending", 32'(bus.cfg_pending), 32'd1);
        cfg_write(2'd0, 7'd3, 8'h55);
        cfg_read(2'd0, 7'd3, 8'h11, "rd_drop_a3");
        bus.in_vsync = 1'b1;
        tick();
        check("swap2_pending_clr", 32'(bus.cfg_pending), 32'd0);
        bus.in_vsync = 1'b0;
        tick();
        cfg_read(2'd1, 7'd5,  8'd100, "rd_old_active_g5");
        cfg_read(2'd0, 7'd65, 8'd0,   "rd2_addr65");
        pixel_check(12'hABC, 12'h170, 12'h060, 8'hAB, 8'h17, 8'h06, "swap2_byp");

        // Commit coincident with the vsync rise swaps at once
        bus.cfg_bypass = 1'b0;
        bus.in_vsync   = 1'b1;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        check("coinc_pending0", 32'(bus.cfg_pending), 32'd0);
        tick();
        check("coinc_pending1", 32'(bus.cfg_pending), 32'd0);
        bus.in_vsync = 1'b0;
        tick();
        cfg_read(2'd0, 7'd3, 8'h11, "rd_stale_a3");
        pixel_check(12'h060, 12'h170, 12'hFFF, 8'd6, 8'd55, 8'd255, "coinc_curve");

        // Reset with a pending commit; vsync high across reset release
        commit_pulse();
        check("commit3_pending", 32'(bus.cfg_pending), 32'd1);
        bus.in_vsync = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pending_clr", 32'(bus.cfg_pending), 32'd0);
        tick();
        commit_pulse();
        tick();
        check("no_edge_pending", 32'(bus.cfg_pending), 32'd1);
        pixel_check(12'hABC, 12'h170, 12'h060, 8'hAB, 8'h17, 8'h06, "rst_byp");
        bus.in_vsync = 1'b0;
        tick();
        bus.in_vsync = 1'b1;
        tick();
        check("rst_swap_pending_clr", 32'(bus.cfg_pending), 32'd0);
        bus.in_vsync = 1'b0;
        pixel_check(12'h060, 12'h170, 12'hFFF, 8'd6, 8'd55, 8'd255, "rst_swap_curve");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
